// File: rtl/l2_burst_ctrl.sv
// L2 burst controller: splits a read/write burst into single-word handshaked memory accesses; L2_BURST_WRAP_EN selects line-wrapped addressing.
// Latency: first beat two cycles after the request with a zero-wait memory; each beat costs two cycles plus memory wait cycles.
// Backpressure: memory stalls by withholding mem_ack; upstream is paced by l2_busy and requests arriving mid-burst are dropped and flagged.
module l2_burst_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic        l2_rreq,
   input  logic        l2_wreq,
   input  logic [31:0] l2_addr,
   input  logic [4:0]  l2_burst_size,
   input  logic [31:0] l2_wdata,
   output logic        l2_busy,
   output logic [31:0] l2_rdata,
   output logic        l2_overrun,
   output logic        mem_en,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      R_REQ  = 3'd1,
      R_BEAT = 3'd2,
      W_REQ  = 3'd3,
      W_BEAT = 3'd4
   } state_t;

   state_t      state, state_nxt;
   logic [31:0] addr_q;
   logic [31:0] addr_inc;
   logic [5:0]  cnt_q;
   logic        req_any;
   logic        unused_addr_bits;

   assign req_any          = l2_rreq | l2_wreq;
   assign mem_addr         = addr_q;
   assign mem_wdata        = l2_wdata;
   assign unused_addr_bits = ^{l2_addr[1:0], addr_q[1:0]};

`ifdef L2_BURST_WRAP_EN
   // Critical-word-first refill: stay inside the aligned 32-byte line.
   assign addr_inc = {addr_q[31:5], 3'(addr_q[4:2] + 3'd1), 2'b00};
`else
   assign addr_inc = addr_q + 32'd4;
`endif

   always_comb begin
      state_nxt = state;
      l2_busy   = 1'b1;
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      case (state)
         IDLE: begin
            if (l2_rreq)      state_nxt = R_REQ;
            else if (l2_wreq) state_nxt = W_REQ;
         end
         R_REQ: begin
            mem_en = 1'b1;
            if (mem_ack) state_nxt = R_BEAT;
         end
         R_BEAT: begin
            l2_busy   = 1'b0;
            state_nxt = (cnt_q == 6'd1) ? IDLE : R_REQ;
         end
         W_REQ: begin
            mem_en = 1'b1;
            mem_we = 1'b1;
            if (mem_ack) state_nxt = W_BEAT;
         end
         W_BEAT: begin
            l2_busy   = 1'b0;
            state_nxt = (cnt_q == 6'd1) ? IDLE : W_REQ;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         addr_q     <= 32'd0;
         cnt_q      <= 6'd0;
         l2_rdata   <= 32'd0;
         l2_overrun <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (req_any) begin
                  addr_q <= {l2_addr[31:2], 2'b00};
                  cnt_q  <= (l2_burst_size == 5'd0) ? 6'd32 : {1'b0, l2_burst_size};
               end
            end
            R_REQ: begin
               if (mem_ack) l2_rdata <= mem_rdata;
            end
            R_BEAT, W_BEAT: begin
               addr_q <= addr_inc;
               cnt_q  <= cnt_q - 6'd1;
            end
            default: ;
         endcase
         // Simultaneous read+write in IDLE loses the write, so it counts as an overrun too.
         if (((state != IDLE) && req_any) || ((state == IDLE) && l2_rreq && l2_wreq))
            l2_overrun <= 1'b1;
      end
   end

endmodule

// File: tb/tb_l2_burst_ctrl.sv
// Bench for l2_burst_ctrl: directed bursts against a memory model with configurable ack delay, queue-based scoreboard.
module tb_l2_burst_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        l2_rreq, l2_wreq;
   logic [31:0] l2_addr;
   logic [4:0]  l2_burst_size;
   logic [31:0] l2_wdata;
   logic        l2_busy;
   logic [31:0] l2_rdata;
   logic        l2_overrun;
   logic        mem_en, mem_we;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_ack;

   l2_burst_ctrl dut (
      .clk(clk), .reset(reset),
      .l2_rreq(l2_rreq), .l2_wreq(l2_wreq), .l2_addr(l2_addr),
      .l2_burst_size(l2_burst_size), .l2_wdata(l2_wdata),
      .l2_busy(l2_busy), .l2_rdata(l2_rdata), .l2_overrun(l2_overrun),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      int          len;
   } acc_t;
   typedef struct {
      logic [31:0] rdata;
      int          cyc;
   } beat_t;

   acc_t  acc_q[$];
   beat_t beat_q[$];
   int    checks = 0;
   int    errors = 0;
   int    wait_cfg = 0;
   int    wcnt = 0;
   int    en_run = 0;
   logic [31:0] last_rd = 32'd0;

   // Memory model: acks after wait_cfg wait cycles, returns address-derived data.
   assign mem_ack   = (mem_en === 1'b1) && (wcnt >= wait_cfg);
   assign mem_rdata = mem_addr ^ 32'hA5A5_0000;
   always @(posedge clk) begin
      if (mem_en !== 1'b1 || mem_ack) wcnt <= 0;
      else wcnt <= wcnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] nxt(input logic [31:0] a);
`ifdef L2_BURST_WRAP_EN
      return {a[31:5], 3'(a[4:2] + 3'd1), 2'b00};
`else
      return a + 32'd4;
`endif
   endfunction

   always @(negedge clk) begin
      acc_t  a;
      beat_t b;
      if (mem_en === 1'b1) begin
         en_run++;
         if (acc_q.size() == 0) begin
            chk("spurious_access", mem_addr, 32'hxxxx_xxxx);
         end else begin
            chk("mem_addr", mem_addr, acc_q[0].addr);
            chk("mem_we", 32'(mem_we), 32'(acc_q[0].we));
            chk("mem_wdata", mem_wdata, l2_wdata);
            if (mem_ack) begin
               a = acc_q.pop_front();
               chk("mem_en_len", 32'(en_run), 32'(a.len));
               en_run = 0;
            end
         end
      end else begin
         en_run = 0;
      end
      if (l2_busy === 1'b0) begin
         if (beat_q.size() == 0) begin
            chk("spurious_beat", 32'(cyc), 32'hxxxx_xxxx);
         end else begin
            b = beat_q.pop_front();
            chk("beat_cycle", 32'(cyc), 32'(b.cyc));
            chk("l2_rdata", l2_rdata, b.rdata);
         end
         l2_wdata = $urandom;
      end
   end

   task automatic goto(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic burst(input logic wr, input logic [31:0] a0, input logic [4:0] sz,
                        input logic both, output int t0);
      int n;
      logic [31:0] a;
      t0 = cyc;
      n  = (sz == 5'd0) ? 32 : int'(sz);
      a  = {a0[31:2], 2'b00};
      for (int k = 0; k < n; k++) begin
         acc_q.push_back('{a, wr, wait_cfg + 1});
         if (!wr) last_rd = a ^ 32'hA5A5_0000;
         beat_q.push_back('{last_rd, t0 + (wait_cfg + 2) * (k + 1)});
         a = nxt(a);
      end
      l2_rreq       = !wr || both;
      l2_wreq       = wr || both;
      l2_addr       = a0;
      l2_burst_size = sz;
      @(posedge clk);
      #1;
      l2_rreq = 1'b0;
      l2_wreq = 1'b0;
   endtask

   task automatic drained(input string tag);
      chk({tag, "_beats_left"}, 32'(beat_q.size()), 32'd0);
      chk({tag, "_acc_left"}, 32'(acc_q.size()), 32'd0);
   endtask

   initial begin
      int t, t2;
      reset = 1'b1;
      l2_rreq = 1'b0;
      l2_wreq = 1'b0;
      l2_addr = 32'd0;
      l2_burst_size = 5'd0;
      l2_wdata = 32'h1234_5678;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", 32'(l2_busy), 32'd1);
      chk("rst_rdata", l2_rdata, 32'd0);
      chk("rst_overrun", 32'(l2_overrun), 32'd0);
      chk("rst_mem_en", 32'(mem_en), 32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      reset = 1'b0;
      @(posedge clk);
      #1;

      // Zero-wait read, size 4; next request at the earliest legal cycle T+9.
      wait_cfg = 0;
      burst(1'b0, 32'h0000_0100, 5'd4, 1'b0, t);
      goto(t + 9);
      drained("rd4");
      chk("rd4_idle_busy", 32'(l2_busy), 32'd1);
      chk("rd4_idle_en", 32'(mem_en), 32'd0);

      // Write size 2 with three wait cycles per beat.
      wait_cfg = 3;
      burst(1'b1, 32'h0000_0040, 5'd2, 1'b0, t);
      goto(t + 12);
      drained("wr2");
      chk("wr2_overrun", 32'(l2_overrun), 32'd0);

      // Size 0 means 32 beats, starting near a line end.
      wait_cfg = 0;
      burst(1'b0, 32'h0000_001C, 5'd0, 1'b0, t);
      goto(t + 66);
      drained("rd32");

      // Second request mid-burst is ignored but flagged.
      burst(1'b0, 32'h0000_0300, 5'd4, 1'b0, t);
      goto(t + 3);
      l2_rreq = 1'b1;
      l2_addr = 32'h0000_0700;
      l2_burst_size = 5'd1;
      @(posedge clk);
      #1;
      l2_rreq = 1'b0;
      goto(t + 9);
      drained("ovr");
      chk("ovr_set", 32'(l2_overrun), 32'd1);
      goto(t + 20);
      chk("ovr_sticky", 32'(l2_overrun), 32'd1);

      // Reset at T+3 of a size-8 read abandons the rest of the burst.
      t = cyc;
      acc_q.push_back('{32'h0000_0800, 1'b0, 1});
      acc_q.push_back('{32'h0000_0804, 1'b0, 1});
      beat_q.push_back('{32'h0000_0800 ^ 32'hA5A5_0000, t + 2});
      l2_rreq = 1'b1;
      l2_addr = 32'h0000_0800;
      l2_burst_size = 5'd8;
      @(posedge clk);
      #1;
      l2_rreq = 1'b0;
      goto(t + 3);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      last_rd = 32'd0;
      chk("mrst_mem_en", 32'(mem_en), 32'd0);
      chk("mrst_busy", 32'(l2_busy), 32'd1);
      chk("mrst_overrun", 32'(l2_overrun), 32'd0);
      chk("mrst_rdata", l2_rdata, 32'd0);
      drained("mrst");
      burst(1'b0, 32'h0000_0202, 5'd3, 1'b0, t2);
      goto(t2 + 7);
      drained("post_rst");
      chk("post_rst_overrun", 32'(l2_overrun), 32'd0);

      // Read and write together: read wins, overrun set.
      burst(1'b0, 32'h0000_0900, 5'd1, 1'b1, t);
      goto(t + 3);
      drained("both");
      chk("both_overrun", 32'(l2_overrun), 32'd1);

      // Top of address space.
      burst(1'b0, 32'hFFFF_FFFC, 5'd2, 1'b0, t);
      goto(t + 6);
      drained("top");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/l2_burst_ctrl.md
# l2_burst_ctrl

- Sits directly downstream of the L1-to-L2 request arbiter.
- Accepts a one-cycle read or write burst request (address, beat count) and breaks it into single-word accesses on a simple handshaked memory port.
- Reports each completed beat upstream by dropping `l2_busy` low for exactly one cycle. On reads, the word is valid on `l2_rdata` during that cycle.
- Serves one burst at a time. A request arriving mid-burst is a protocol violation and is flagged.

## Interface
- Reset: `reset`, synchronous, active-high. Clock: `clk`.
- No parameters.
- `clk` in 1 — clock
- `reset` in 1 — synchronous, active-high
- `l2_rreq` in 1 — read burst request, one-cycle pulse
- `l2_wreq` in 1 — write burst request, one-cycle pulse
- `l2_addr` in 32 — start byte address; bits [1:0] ignored
- `l2_burst_size` in 5 — beat count; 0 means 32
- `l2_wdata` in 32 — write word for the current beat; upstream holds it stable until that beat's busy-low cycle
- `l2_busy` out 1 — 0 for one cycle per completed beat, 1 otherwise
- `l2_rdata` out 32 — read word, valid in the busy-low cycle of a read beat
- `l2_overrun` out 1 — sticky; set when a request arrives while not IDLE
- `mem_en` out 1 — memory access request; held until `mem_ack`
- `mem_we` out 1 — 1 = write access
- `mem_addr` out 32 — word-aligned access address
- `mem_wdata` out 32 — combinational pass-through of `l2_wdata`
- `mem_rdata` in 32 — read data, valid with `mem_ack`
- `mem_ack` in 1 — access complete; may assert in the same cycle as `mem_en`

## Operation
- States: IDLE, R_REQ, R_BEAT, W_REQ, W_BEAT.
- Reset values:
  - state IDLE
  - `l2_busy`=1, `l2_rdata`=0, `l2_overrun`=0
  - `mem_en`=0, `mem_we`=0, `mem_addr`=0
  - beat counter 0
- **IDLE**, `l2_busy`=1:
  - On `l2_rreq`: latch `{l2_addr[31:2],2'b00}` into the address register and the beat count into a 6-bit counter (0 → 32), then go to R_REQ.
  - On `l2_wreq`: same latching, then go to W_REQ.
  - Both high in the same cycle: read wins; the write is dropped and `l2_overrun` is set.
- **R_REQ**: `mem_en`=1, `mem_we`=0, `mem_addr`=address register. On `mem_ack`: register `mem_rdata` into `l2_rdata`, go to R_BEAT.
- **R_BEAT**: `l2_busy`=0, `mem_en`=0.
  - Advance the address register, decrement the counter.
  - If the counter was 1, go to IDLE; otherwise go to R_REQ.
- **W_REQ**: `mem_en`=1, `mem_we`=1. On `mem_ack`, go to W_BEAT.
- **W_BEAT**: same as R_BEAT, returning to W_REQ. `l2_rdata` is unchanged.
- `l2_rdata` holds its last value outside R_BEAT.
- Any `l2_rreq`/`l2_wreq` while not IDLE:
  - is ignored;
  - sets `l2_overrun`, which stays set until reset;
  - does not disturb the current burst.
- Address advance: +4, 32-bit, wraps at 2^32 (see Configuration).
- `mem_addr`/`mem_we` are stable for the whole time `mem_en` is high.

## Timing
- Request at cycle T:
  - R_REQ/W_REQ from T+1.
  - With a zero-wait memory (`mem_ack` in the same cycle as `mem_en`), first busy-low at T+2.
- Each memory wait cycle adds one cycle per beat.
- Burst of N beats with zero wait: busy low at T+2, T+4, …, T+2N; back in IDLE at T+2N+1.
- Earliest next accepted request: cycle T+2N+1.
- `l2_busy` is never low in two consecutive cycles.
- Reset asserted mid-burst: IDLE on the next edge; `mem_en` drops; the outstanding memory access is abandoned; the remaining beats are discarded.

## Configuration
- `L2_BURST_WRAP_EN`:
  - Defined: the beat address wraps within the aligned 32-byte line. `addr[4:2]` increments modulo 8 and `addr[31:5]` stays fixed (critical-word-first refill).
  - Undefined: the address increments linearly by 4 across line boundaries.

## Test plan
- Read burst, `l2_addr`=0x100, size 4, zero-wait memory returning `addr^0xA5A5_0000`:
  - `mem_addr` 0x100/0x104/0x108/0x10C;
  - busy low at T+2/4/6/8 with the matching `l2_rdata`;
  - IDLE at T+9.
- Write burst, size 2, `mem_ack` delayed 3 cycles per beat:
  - `mem_en`/`mem_we` held 4 cycles per beat;
  - busy low at T+5 and T+10;
  - `mem_wdata` equals `l2_wdata` throughout.
- Size 0, `l2_addr`=0x1C:
  - exactly 32 busy-low cycles.
  - Wrap defined: `mem_addr` sequence 0x1C, 0x00, 0x04, … repeating within 0x00–0x1C.
  - Wrap undefined: 0x1C, 0x20, … 0x98.
- `l2_rreq` pulsed again at T+3 of a size-4 read:
  - burst completes unchanged with 4 beats;
  - `l2_overrun`=1 and stays 1.
- `reset` asserted at T+3 of a size-8 read:
  - next cycle `mem_en`=0, `l2_busy`=1, `l2_overrun`=0;
  - a new read accepted immediately after reset completes normally.
- `l2_addr`=0xFFFF_FFFC, size 2, wrap undefined: `mem_addr` 0xFFFF_FFFC then 0x0000_0000.
